lc3_mem_arbiter: RTL and testbench
==================================

Name: lc3_mem_arbiter

Overview:
Two-port arbiter and sequencer in front of the LC-3 Memory block. It shares the single memory port between the CPU control FSM (fetch/load/store) and the debug/program-loader port, which replaces the ad-hoc MARSpcIn/MDRSpcIn/ldMARSpcIn path. Each requester uses a req/ack handshake. The arbiter issues one memory access at a time, counts out the fixed memory latency, and returns registered read data with a one-cycle ack.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
MEM_LAT, 1, cycles from mem_en to valid mem_rdata (legal range 1..7)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU access request; held until cpu_ack
cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  read data, valid while cpu_ack
dbg_req  in  1  debug/loader request
dbg_we  in  1  debug write enable
dbg_addr  in  ADDR_W  debug address
dbg_wdata  in  DATA_W  debug write data
dbg_ack  out  1  debug completion pulse
dbg_rdata  out  DATA_W  debug read data, valid while dbg_ack
mem_en  out  1  memory access strobe, one cycle per access
mem_we  out  1  memory write strobe, only together with mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
busy  out  1  high in any state other than IDLE
grant_dbg  out  1  current or last grant belongs to debug

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values: state=IDLE; all acks, mem_en, mem_we, busy = 0; mem_addr, mem_wdata, rdata registers = 0; last_grant=DBG, so the CPU wins the first tie; grant_dbg=0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any req is high, pick a winner:
  - only one req high: that requester wins;
  - both high: the requester that is not last_grant wins (round-robin).
  - Latch the winner's we/addr/wdata into registers, set last_grant and grant_dbg, and go to ACCESS. Otherwise stay in IDLE.
- ACCESS: lasts exactly MEM_LAT cycles, counted by lat_cnt.
  - mem_en=1 in the first ACCESS cycle only; mem_we = latched we in that cycle only.
  - mem_addr and mem_wdata are held for all ACCESS cycles.
  - At the edge ending the last ACCESS cycle, capture mem_rdata into rdata_q and go to RESP.
- RESP: pulse the winner's ack for exactly one cycle.
  - rdata_q drives the winner's rdata; rdata_q is also captured on writes and is don't-care for writers.
  - Next state is always IDLE. No arbitration happens in RESP, because the acked req is still high that cycle.
- Latency: req first seen in IDLE in cycle 0 -> mem_en in cycle 1 -> ack in cycle MEM_LAT+1 -> IDLE in cycle MEM_LAT+2.
  - Back-to-back throughput is one access per MEM_LAT+2 cycles.
- Handshake rules:
  - A requester holds req and its payload until ack, and drops req in the cycle after ack (it may re-raise it later).
  - A req dropped before ack is illegal; the arbiter still completes the access and pulses ack.
  - cpu_ack and dbg_ack are never high together.
- Fairness: under continuous contention, grants alternate CPU, DBG, CPU, ...
- Reset mid-operation: return to IDLE immediately. mem_en and mem_we drop asynchronously. No ack is issued for the aborted access; an aborted write may be lost.
- Address and data pass through unmodified; widths must match. No wrap or arithmetic is performed.

Optional Feature:
LC3_ARB_PERF_EN — adds outputs perf_cpu_cnt[15:0], perf_dbg_cnt[15:0] and perf_wait_cnt[15:0].
- perf_cpu_cnt and perf_dbg_cnt increment on each corresponding ack.
- perf_wait_cnt increments each cycle in which a req is high but its owner is not the current grant, or the req is pending in ACCESS/RESP.
- All three counters saturate at 16'hFFFF and reset to 0.
- Without the macro these ports and their logic are absent, and the block's behaviour is otherwise identical.

Decomposition:
- Package lc3_arb_pkg: state enum (IDLE, ACCESS, RESP); requester ID constants GNT_CPU=0, GNT_DBG=1; default ADDR_W/DATA_W constants; MEM_LAT counter width localparam (3 bits).
- Sub-module lc3_rr_arb2: combinational two-way round-robin pick from (cpu_req, dbg_req, last_grant). Outputs grant_valid and grant_id.

Test Plan:
- Reset: assert reset mid-ACCESS with MEM_LAT=3 -> mem_en=0 and busy=0 immediately; no ack pulse follows; after release, the first tie grants the CPU.
- Single CPU read: MEM_LAT=1, cpu_req with addr 16'h3000, memory model returns 16'h1234 -> mem_en in cycle 1 only, cpu_ack in cycle 2 with cpu_rdata=16'h1234, busy low in cycle 3.
- Debug write: dbg_we=1, addr 16'h0200, wdata 16'hBEEF -> one-cycle mem_en and mem_we with those values, dbg_ack at cycle MEM_LAT+1, model memory holds 16'hBEEF.
- Contention: cpu_req and dbg_req held high for 6 accesses -> grant order CPU, DBG, CPU, DBG, CPU, DBG; acks never overlap.
- Latency sweep: MEM_LAT=4, CPU read -> mem_addr held for 4 cycles, mem_en high only in the first; ack in cycle 5 carrying data sampled at the end of cycle 4.
- LC3_ARB_PERF_EN: 3 CPU and 2 DBG accesses under contention -> perf_cpu_cnt=3, perf_dbg_cnt=2, perf_wait_cnt nonzero; with the counters preloaded near the limit, they saturate at 16'hFFFF.

Source files
------------

// File: rtl/lc3_arb_pkg.sv
// lc3_arb_pkg: shared types and constants for the LC-3 memory arbiter.
package lc3_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  // Requester identifiers, also the encoding of last_grant.
  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_DBG = 1'b1;

  localparam int ARB_ADDR_W = 16;
  localparam int ARB_DATA_W = 16;

  // Wide enough to count MEM_LAT-1 for MEM_LAT up to 7.
  localparam int LAT_CNT_W = 3;

  localparam int PERF_W = 16;

  // Saturating increment for the optional performance counters.
  function automatic logic [PERF_W-1:0] perf_sat_inc(input logic [PERF_W-1:0] v);
    logic [PERF_W-1:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lc3_rr_arb2.sv
// lc3_rr_arb2: combinational two-way round-robin pick between CPU and debug.
module lc3_rr_arb2
  import lc3_arb_pkg::*;
(
  input  logic cpu_req_i,
  input  logic dbg_req_i,
  input  logic last_grant_i,
  output logic grant_valid_o,
  output logic grant_id_o
);

  // A lone requester wins; on a tie the side that was not served last wins.
  always_comb begin
    grant_valid_o = cpu_req_i | dbg_req_i;
    grant_id_o    = GNT_CPU;
    if (cpu_req_i && dbg_req_i) begin
      grant_id_o = (last_grant_i == GNT_CPU) ? GNT_DBG : GNT_CPU;
    end else if (dbg_req_i) begin
      grant_id_o = GNT_DBG;
    end else begin
      grant_id_o = GNT_CPU;
    end
  end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// lc3_mem_arbiter: shares the single LC-3 memory port between the CPU
// control FSM and the debug/program-loader port, one access at a time.
// Optional feature macro: LC3_ARB_PERF_EN (ack and wait counters).
module lc3_mem_arbiter
  import lc3_arb_pkg::*;
#(
  parameter int ADDR_W  = ARB_ADDR_W,
  parameter int DATA_W  = ARB_DATA_W,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_dbg
`ifdef LC3_ARB_PERF_EN
  ,
  output logic [15:0]       perf_cpu_cnt,
  output logic [15:0]       perf_dbg_cnt,
  output logic [15:0]       perf_wait_cnt
`endif
);

  localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(MEM_LAT - 1);

  arb_state_e           state_q, state_d;
  logic [LAT_CNT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 last_grant_q, last_grant_d;
  logic                 grant_dbg_q, grant_dbg_d;
  logic                 cpu_ack_q, cpu_ack_d;
  logic                 dbg_ack_q, dbg_ack_d;
  logic                 mem_en_q, mem_en_d;
  logic                 mem_we_q, mem_we_d;
  logic                 busy_q, busy_d;
  logic                 grant_valid_s;
  logic                 grant_id_s;

  lc3_rr_arb2 u_rr_arb (
    .cpu_req_i     (cpu_req),
    .dbg_req_i     (dbg_req),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (grant_valid_s),
    .grant_id_o    (grant_id_s)
  );

  // Next-state and registered-output logic for the IDLE/ACCESS/RESP sequencer.
  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    last_grant_d = last_grant_q;
    grant_dbg_d  = grant_dbg_q;
    cpu_ack_d    = 1'b0;
    dbg_ack_d    = 1'b0;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid_s) begin
          last_grant_d = grant_id_s;
          grant_dbg_d  = (grant_id_s == GNT_DBG);
          if (grant_id_s == GNT_DBG) begin
            we_d    = dbg_we;
            addr_d  = dbg_addr;
            wdata_d = dbg_wdata;
          end else begin
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
          end
          // The strobe is launched here so it is visible in the first ACCESS cycle.
          mem_en_d  = 1'b1;
          mem_we_d  = (grant_id_s == GNT_DBG) ? dbg_we : cpu_we;
          lat_cnt_d = 3'd0;
          state_d   = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (lat_cnt_q == LAT_LAST) begin
          rdata_d = mem_rdata;
          state_d = RESP;
          if (last_grant_q == GNT_DBG) begin
            dbg_ack_d = 1'b1;
          end else begin
            cpu_ack_d = 1'b1;
          end
        end else begin
          lat_cnt_d = lat_cnt_q + 3'd1;
        end
      end
      RESP: begin
        // The acked req is still high here, so no arbitration in this state.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, payload and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      lat_cnt_q    <= 3'd0;
      we_q         <= 1'b0;
      addr_q       <= {ADDR_W{1'b0}};
      wdata_q      <= {DATA_W{1'b0}};
      rdata_q      <= {DATA_W{1'b0}};
      last_grant_q <= GNT_DBG;
      grant_dbg_q  <= 1'b0;
      cpu_ack_q    <= 1'b0;
      dbg_ack_q    <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      last_grant_q <= last_grant_d;
      grant_dbg_q  <= grant_dbg_d;
      cpu_ack_q    <= cpu_ack_d;
      dbg_ack_q    <= dbg_ack_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      busy_q       <= busy_d;
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign dbg_ack   = dbg_ack_q;
  assign cpu_rdata = rdata_q;
  assign dbg_rdata = rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
  assign grant_dbg = grant_dbg_q;

`ifdef LC3_ARB_PERF_EN
  logic [15:0] perf_cpu_q, perf_dbg_q, perf_wait_q;
  logic        wait_s;

  // A cycle is a wait cycle when a tie is lost in IDLE or any req is pending while busy.
  always_comb begin
    wait_s = 1'b0;
    if (state_q == IDLE) begin
      wait_s = cpu_req & dbg_req;
    end else begin
      wait_s = cpu_req | dbg_req;
    end
  end

  // Saturating performance counters, bumped together with the ack they count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cpu_q  <= 16'd0;
      perf_dbg_q  <= 16'd0;
      perf_wait_q <= 16'd0;
    end else begin
      perf_cpu_q  <= cpu_ack_d ? perf_sat_inc(perf_cpu_q) : perf_cpu_q;
      perf_dbg_q  <= dbg_ack_d ? perf_sat_inc(perf_dbg_q) : perf_dbg_q;
      perf_wait_q <= wait_s ? perf_sat_inc(perf_wait_q) : perf_wait_q;
    end
  end

  assign perf_cpu_cnt  = perf_cpu_q;
  assign perf_dbg_cnt  = perf_dbg_q;
  assign perf_wait_cnt = perf_wait_q;
`endif

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// tb_lc3_mem_arbiter: directed bench for lc3_mem_arbiter. Three instances run
// at MEM_LAT = 1, 3 and 4; instance 0 has a small memory model behind it.
module tb_lc3_mem_arbiter;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset     [N];
  logic        cpu_req   [N];
  logic        cpu_we    [N];
  logic [15:0] cpu_addr  [N];
  logic [15:0] cpu_wdata [N];
  logic        cpu_ack   [N];
  logic [15:0] cpu_rdata [N];
  logic        dbg_req   [N];
  logic        dbg_we    [N];
  logic [15:0] dbg_addr  [N];
  logic [15:0] dbg_wdata [N];
  logic        dbg_ack   [N];
  logic [15:0] dbg_rdata [N];
  logic        mem_en    [N];
  logic        mem_we    [N];
  logic [15:0] mem_addr  [N];
  logic [15:0] mem_wdata [N];
  logic [15:0] rd_drv    [N];
  logic        busy      [N];
  logic        grant_dbg [N];
`ifdef LC3_ARB_PERF_EN
  logic [15:0] perf_cpu_cnt  [N];
  logic [15:0] perf_dbg_cnt  [N];
  logic [15:0] perf_wait_cnt [N];
`endif

  // Memory model for instance 0: combinational read, write on the clock edge.
  logic [15:0] mem0 [0:65535];
  logic [15:0] mem0_rd;
  logic        pre_en;
  logic [15:0] pre_addr, pre_data;

  always @(posedge clk) begin
    if (pre_en) begin
      mem0[pre_addr] <= pre_data;
    end else if (mem_en[0] && mem_we[0]) begin
      mem0[mem_addr[0]] <= mem_wdata[0];
    end
  end
  assign mem0_rd = mem0[mem_addr[0]];

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) u_dut (
      .clk       (clk),
      .reset     (reset[g]),
      .cpu_req   (cpu_req[g]),
      .cpu_we    (cpu_we[g]),
      .cpu_addr  (cpu_addr[g]),
      .cpu_wdata (cpu_wdata[g]),
      .cpu_ack   (cpu_ack[g]),
      .cpu_rdata (cpu_rdata[g]),
      .dbg_req   (dbg_req[g]),
      .dbg_we    (dbg_we[g]),
      .dbg_addr  (dbg_addr[g]),
      .dbg_wdata (dbg_wdata[g]),
      .dbg_ack   (dbg_ack[g]),
      .dbg_rdata (dbg_rdata[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata ((g == 0) ? mem0_rd : rd_drv[g]),
      .busy      (busy[g]),
      .grant_dbg (grant_dbg[g])
`ifdef LC3_ARB_PERF_EN
      ,
      .perf_cpu_cnt  (perf_cpu_cnt[g]),
      .perf_dbg_cnt  (perf_dbg_cnt[g]),
      .perf_wait_cnt (perf_wait_cnt[g])
`endif
    );
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold both reqs, expect acks alternating CPU first, spaced MEM_LAT+2 apart.
  task automatic run_tie(input int idx, input int n_acc, input int lat, input string tag);
    int got = 0;
    int cyc = 0;
    int ovl = 0;
    cpu_req[idx]  = 1'b1;
    cpu_we[idx]   = 1'b0;
    cpu_addr[idx] = 16'h0010;
    dbg_req[idx]  = 1'b1;
    dbg_we[idx]   = 1'b0;
    dbg_addr[idx] = 16'h0020;
    while (got < n_acc && cyc < 100) begin
      tick();
      cyc++;
      if (cpu_ack[idx] && dbg_ack[idx]) ovl++;
      if (cpu_ack[idx] || dbg_ack[idx]) begin
        check_eq($sformatf("%s_id%0d", tag, got), 32'(dbg_ack[idx]), 32'(got % 2));
        check_eq($sformatf("%s_cyc%0d", tag, got), 32'(cyc), 32'((lat + 1) + (lat + 2) * got));
        got++;
        if (got == n_acc) begin
          cpu_req[idx] = 1'b0;
          dbg_req[idx] = 1'b0;
        end
      end
    end
    cpu_req[idx] = 1'b0;
    dbg_req[idx] = 1'b0;
    check_eq({tag, "_count"}, 32'(got), 32'(n_acc));
    check_eq({tag, "_overlap"}, 32'(ovl), 32'd0);
    tick();
    check_eq({tag, "_idle"}, 32'(busy[idx]), 32'd0);
  endtask

  initial begin
    int ack_seen;
    for (int i = 0; i < N; i++) begin
      reset[i]     = 1'b1;
      cpu_req[i]   = 1'b0;
      cpu_we[i]    = 1'b0;
      cpu_addr[i]  = 16'h0000;
      cpu_wdata[i] = 16'h0000;
      dbg_req[i]   = 1'b0;
      dbg_we[i]    = 1'b0;
      dbg_addr[i]  = 16'h0000;
      dbg_wdata[i] = 16'h0000;
      rd_drv[i]    = 16'h0000;
    end
    pre_en   = 1'b1;
    pre_addr = 16'h3000;
    pre_data = 16'h1234;
    tick();
    pre_en = 1'b0;

    // Reset values
    check_eq("rst_busy",  32'(busy[0]),      32'd0);
    check_eq("rst_en",    32'(mem_en[0]),    32'd0);
    check_eq("rst_we",    32'(mem_we[0]),    32'd0);
    check_eq("rst_cack",  32'(cpu_ack[0]),   32'd0);
    check_eq("rst_dack",  32'(dbg_ack[0]),   32'd0);
    check_eq("rst_addr",  32'(mem_addr[0]),  32'd0);
    check_eq("rst_wdata", 32'(mem_wdata[0]), 32'd0);
    check_eq("rst_rdata", 32'(cpu_rdata[0]), 32'd0);
    check_eq("rst_gdbg",  32'(grant_dbg[0]), 32'd0);
    tick();
    for (int i = 0; i < N; i++) reset[i] = 1'b0;
    tick();

    // Single CPU read, MEM_LAT=1
    cpu_req[0]  = 1'b1;
    cpu_we[0]   = 1'b0;
    cpu_addr[0] = 16'h3000;
    check_eq("rd_c0_en", 32'(mem_en[0]), 32'd0);
    tick();
    check_eq("rd_c1_en",   32'(mem_en[0]),   32'd1);
    check_eq("rd_c1_we",   32'(mem_we[0]),   32'd0);
    check_eq("rd_c1_addr", 32'(mem_addr[0]), 32'h3000);
    check_eq("rd_c1_busy", 32'(busy[0]),     32'd1);
    check_eq("rd_c1_ack",  32'(cpu_ack[0]),  32'd0);
    tick();
    check_eq("rd_c2_en",    32'(mem_en[0]),    32'd0);
    check_eq("rd_c2_ack",   32'(cpu_ack[0]),   32'd1);
    check_eq("rd_c2_dack",  32'(dbg_ack[0]),   32'd0);
    check_eq("rd_c2_rdata", 32'(cpu_rdata[0]), 32'h1234);
    check_eq("rd_c2_gdbg",  32'(grant_dbg[0]), 32'd0);
    cpu_req[0] = 1'b0;
    tick();
    check_eq("rd_c3_busy", 32'(busy[0]),    32'd0);
    check_eq("rd_c3_ack",  32'(cpu_ack[0]), 32'd0);

    // Debug write, MEM_LAT=1
    dbg_req[0]   = 1'b1;
    dbg_we[0]    = 1'b1;
    dbg_addr[0]  = 16'h0200;
    dbg_wdata[0] = 16'hBEEF;
    tick();
    check_eq("wr_c1_en",    32'(mem_en[0]),    32'd1);
    check_eq("wr_c1_we",    32'(mem_we[0]),    32'd1);
    check_eq("wr_c1_addr",  32'(mem_addr[0]),  32'h0200);
    check_eq("wr_c1_wdata", 32'(mem_wdata[0]), 32'hBEEF);
    check_eq("wr_c1_gdbg",  32'(grant_dbg[0]), 32'd1);
    tick();
    check_eq("wr_c2_en",   32'(mem_en[0]),  32'd0);
    check_eq("wr_c2_we",   32'(mem_we[0]),  32'd0);
    check_eq("wr_c2_dack", 32'(dbg_ack[0]), 32'd1);
    check_eq("wr_c2_cack", 32'(cpu_ack[0]), 32'd0);
    dbg_req[0] = 1'b0;
    dbg_we[0]  = 1'b0;
    tick();
    check_eq("wr_mem", 32'(mem0[16'h0200]), 32'hBEEF);
    check_eq("wr_c3_busy", 32'(busy[0]), 32'd0);

    // Contention: six accesses, CPU first because DBG was served last
    run_tie(0, 6, 1, "cont");

    // Latency sweep, MEM_LAT=4: data changes every ACCESS cycle
    cpu_req[2]  = 1'b1;
    cpu_we[2]   = 1'b0;
    cpu_addr[2] = 16'h3ABC;
    rd_drv[2]   = 16'h0000;
    for (int k = 1; k <= 4; k++) begin
      tick();
      rd_drv[2] = 16'(16'h1111 * k);
      check_eq($sformatf("lat_c%0d_addr", k), 32'(mem_addr[2]), 32'h3ABC);
      check_eq($sformatf("lat_c%0d_en", k),   32'(mem_en[2]),   32'(k == 1));
      check_eq($sformatf("lat_c%0d_ack", k),  32'(cpu_ack[2]),  32'd0);
      check_eq($sformatf("lat_c%0d_busy", k), 32'(busy[2]),     32'd1);
    end
    tick();
    check_eq("lat_c5_ack",   32'(cpu_ack[2]),   32'd1);
    check_eq("lat_c5_rdata", 32'(cpu_rdata[2]), 32'h4444);
    cpu_req[2] = 1'b0;
    tick();
    check_eq("lat_c6_busy", 32'(busy[2]), 32'd0);

    // Reset mid-ACCESS, MEM_LAT=3
    cpu_req[1]  = 1'b1;
    cpu_we[1]   = 1'b0;
    cpu_addr[1] = 16'h0100;
    rd_drv[1]   = 16'h5555;
    tick();
    check_eq("rmid_pre_en", 32'(mem_en[1]), 32'd1);
    reset[1] = 1'b1;
    #1;
    check_eq("rmid_en",   32'(mem_en[1]), 32'd0);
    check_eq("rmid_we",   32'(mem_we[1]), 32'd0);
    check_eq("rmid_busy", 32'(busy[1]),   32'd0);
    cpu_req[1] = 1'b0;
    tick();
    reset[1] = 1'b0;
    ack_seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (cpu_ack[1] || dbg_ack[1]) ack_seen++;
    end
    check_eq("rmid_no_ack", 32'(ack_seen), 32'd0);
    check_eq("rmid_gdbg",   32'(grant_dbg[1]), 32'd0);
    run_tie(1, 1, 3, "rmid_tie");

`ifdef LC3_ARB_PERF_EN
    // Performance counters: 3 CPU and 2 DBG accesses under contention
    reset[1] = 1'b1;
    tick();
    reset[1] = 1'b0;
    check_eq("perf_rst_cpu",  32'(perf_cpu_cnt[1]),  32'd0);
    check_eq("perf_rst_dbg",  32'(perf_dbg_cnt[1]),  32'd0);
    check_eq("perf_rst_wait", 32'(perf_wait_cnt[1]), 32'd0);
    run_tie(1, 5, 3, "perf");
    check_eq("perf_cpu", 32'(perf_cpu_cnt[1]), 32'd3);
    check_eq("perf_dbg", 32'(perf_dbg_cnt[1]), 32'd2);
    check_eq("perf_wait_nz", 32'(perf_wait_cnt[1] != 16'd0), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
